// File: rtl/name_assembler.sv
// Packs a stream of name words into a flat name bus and queues finished names
// in a small FIFO for the FIB lookup side.
module name_assembler #(
    parameter int WORD_SIZE       = 32,
    parameter int MAX_NAME_LENGTH = 8,
    parameter int LEN_SIZE        = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int FIFO_PTR_SIZE   = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [WORD_SIZE-1:0]                 in_word,
    input  logic                                 in_valid,
    input  logic                                 in_last,
    output logic                                 in_ready,
    output logic [MAX_NAME_LENGTH*WORD_SIZE-1:0] name_out,
    output logic [LEN_SIZE-1:0]                  name_len,
    output logic                                 name_trunc,
    output logic                                 name_valid,
    input  logic                                 name_ready,
    output logic [FIFO_PTR_SIZE:0]               fifo_count
);

    localparam int NAME_W = MAX_NAME_LENGTH * WORD_SIZE;
    localparam int CNT_W  = FIFO_PTR_SIZE + 1;

    typedef enum logic {
        COLLECT,
        DISCARD
    } state_e;

    state_e                state_q, state_d;
    logic [NAME_W-1:0]     asm_q, asm_d, asmWritten;
    logic [LEN_SIZE-1:0]   idx_q, idx_d;
    logic                  accept, push, pop, idxAtMax;
    logic [NAME_W-1:0]     pushName;
    logic [LEN_SIZE-1:0]   pushLen;
    logic                  pushTrunc;

    logic [NAME_W-1:0]        memName_q  [FIFO_DEPTH];
    logic [LEN_SIZE-1:0]      memLen_q   [FIFO_DEPTH];
    logic                     memTrunc_q [FIFO_DEPTH];
    logic [FIFO_PTR_SIZE-1:0] wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0]         count_q;

    // in_ready depends only on the registered occupancy, never on name_ready
    assign in_ready   = (count_q != CNT_W'(FIFO_DEPTH));
    assign name_valid = (count_q != '0);
    assign accept     = in_valid && in_ready;
    assign pop        = name_valid && name_ready;
    assign idxAtMax   = (idx_q == LEN_SIZE'(MAX_NAME_LENGTH - 1));

    assign name_out   = memName_q[rdPtr_q];
    assign name_len   = memLen_q[rdPtr_q];
    assign name_trunc = memTrunc_q[rdPtr_q];
    assign fifo_count = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (accept && !in_last && idxAtMax) state_d = DISCARD;
            DISCARD: if (accept && in_last)              state_d = COLLECT;
        endcase
    end

    // Word i lands in the i-th slot from the top so word 0 sits in the MSBs
    always_comb begin
        asmWritten = asm_q;
        for (int i = 0; i < MAX_NAME_LENGTH; i++) begin
            if (idx_q == LEN_SIZE'(i)) begin
                asmWritten[(MAX_NAME_LENGTH-i)*WORD_SIZE-1 -: WORD_SIZE] = in_word;
            end
        end
    end

    always_comb begin
        asm_d     = asm_q;
        idx_d     = idx_q;
        push      = 1'b0;
        pushName  = asmWritten;
        pushLen   = idx_q + LEN_SIZE'(1);
        pushTrunc = 1'b0;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (in_last) begin
                        push  = 1'b1;
                        asm_d = '0;
                        idx_d = '0;
                    end else begin
                        asm_d = asmWritten;
                        if (!idxAtMax) idx_d = idx_q + LEN_SIZE'(1);
                    end
                end
            end
            DISCARD: begin
                pushName  = asm_q;
                pushLen   = LEN_SIZE'(MAX_NAME_LENGTH);
                pushTrunc = 1'b1;
                if (accept && in_last) begin
                    push  = 1'b1;
                    asm_d = '0;
                    idx_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q <= '0;
            idx_q <= '0;
        end else begin
            asm_q <= asm_d;
            idx_q <= idx_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                memName_q[i]  <= '0;
                memLen_q[i]   <= '0;
                memTrunc_q[i] <= 1'b0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                memName_q[wrPtr_q]  <= pushName;
                memLen_q[wrPtr_q]   <= pushLen;
                memTrunc_q[wrPtr_q] <= pushTrunc;
                wrPtr_q             <= wrPtr_q + FIFO_PTR_SIZE'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + FIFO_PTR_SIZE'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_name_assembler.sv
// Scoreboard bench for name_assembler: expected names are queued when driven
// and compared whenever the DUT pops a name.
module tb_name_assembler;

    logic         clk;
    logic         rst;
    logic [31:0]  in_word;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [255:0] name_out;
    logic [3:0]   name_len;
    logic         name_trunc;
    logic         name_valid;
    logic         name_ready;
    logic [2:0]   fifo_count;

    typedef struct {
        logic [255:0] name;
        logic [3:0]   len;
        logic         trunc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        popped;
    logic [31:0] wq[$];
    int          totalCount = 0;
    int          badCount   = 0;

    name_assembler dut (
        .clk        (clk),
        .rst        (rst),
        .in_word    (in_word),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .name_out   (name_out),
        .name_len   (name_len),
        .name_trunc (name_trunc),
        .name_valid (name_valid),
        .name_ready (name_ready),
        .fifo_count (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        totalCount++;
        if (obs !== exp) begin
            badCount++;
            $display("[TB] FAIL %s: got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Expected entry built from the word list: first 8 words, rest zero
    task automatic pushExp();
        exp_t x;
        x.name = '0;
        for (int i = 0; i < wq.size(); i++) begin
            if (i < 8) x.name[(8-i)*32-1 -: 32] = wq[i];
        end
        x.len   = (wq.size() > 8) ? 4'd8 : 4'(wq.size());
        x.trunc = (wq.size() > 8);
        sbq.push_back(x);
    endtask

    task automatic applyStimulus(input logic [31:0] w, input logic last);
        @(negedge clk);
        in_word  = w;
        in_last  = last;
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(negedge clk);
        end
        checkOutput("ready_timeout", 256'(in_ready), 256'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic sendName();
        pushExp();
        for (int i = 0; i < wq.size(); i++) begin
            applyStimulus(wq[i], i == wq.size() - 1);
        end
    endtask

    task automatic setReady(input logic v);
        @(posedge clk);
        #1;
        name_ready = v;
    endtask

    task automatic waitDrain();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !name_valid) return;
        end
        checkOutput("drain_timeout", 256'(sbq.size()), 256'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && name_valid && name_ready) begin
            if (sbq.size() == 0) begin
                checkOutput("sb_underflow", 256'd1, 256'd0);
            end else begin
                popped = sbq.pop_front();
                checkOutput("name_out", name_out, popped.name);
                checkOutput("name_len", 256'(name_len), 256'(popped.len));
                checkOutput("name_trunc", 256'(name_trunc), 256'(popped.trunc));
            end
        end
    end

    initial begin
        rst        = 1'b1;
        in_word    = '0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        name_ready = 1'b1;
        #12;
        checkOutput("rst_valid", 256'(name_valid), 256'd0);
        checkOutput("rst_ready", 256'(in_ready), 256'd1);
        checkOutput("rst_count", 256'(fifo_count), 256'd0);
        checkOutput("rst_name", name_out, 256'd0);
        checkOutput("rst_len", 256'(name_len), 256'd0);
        #10;
        rst = 1'b0;

        // Single short name, one-cycle latency to name_valid
        wq = {32'hAAAA0001, 32'hAAAA0002};
        pushExp();
        applyStimulus(32'hAAAA0001, 1'b0);
        @(negedge clk);
        checkOutput("lat_before", 256'(name_valid), 256'd0);
        applyStimulus(32'hAAAA0002, 1'b1);
        @(negedge clk);
        checkOutput("lat_after", 256'(name_valid), 256'd1);
        waitDrain();

        // Pops while empty are ignored
        repeat (3) @(negedge clk);
        checkOutput("empty_pop_count", 256'(fifo_count), 256'd0);

        // Truncation then a short name
        wq = {};
        for (int i = 1; i <= 10; i++) wq.push_back(32'(i));
        sendName();
        wq = {32'h5};
        sendName();
        waitDrain();

        // Exact-max name followed by a name that must not be truncated
        wq = {};
        for (int i = 1; i <= 8; i++) wq.push_back(32'hB000_0000 + 32'(i));
        sendName();
        wq = {32'hC1, 32'hC2};
        sendName();
        waitDrain();

        // Backpressure: fill FIFO, stall name 5, one pop frees a slot
        setReady(1'b0);
        for (int n = 1; n <= 4; n++) begin
            wq = {32'(n)};
            sendName();
        end
        @(negedge clk);
        wq = {32'd5};
        pushExp();
        in_word  = 32'd5;
        in_last  = 1'b1;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("bp_count", 256'(fifo_count), 256'd4);
        checkOutput("bp_ready", 256'(in_ready), 256'd0);
        @(posedge clk);
        #1;
        name_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_ready_popcycle", 256'(in_ready), 256'd0);
        @(posedge clk);
        #1;
        name_ready = 1'b0;
        @(negedge clk);
        checkOutput("bp_ready_after", 256'(in_ready), 256'd1);
        checkOutput("bp_count_after", 256'(fifo_count), 256'd3);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        checkOutput("bp_count_refill", 256'(fifo_count), 256'd4);
        setReady(1'b1);
        waitDrain();

        // Simultaneous push and pop at occupancy 2
        setReady(1'b0);
        wq = {32'h11};
        sendName();
        wq = {32'h22, 32'h33};
        sendName();
        wq = {32'h44};
        pushExp();
        in_word    = 32'h44;
        in_last    = 1'b1;
        in_valid   = 1'b1;
        name_ready = 1'b1;
        @(negedge clk);
        checkOutput("spp_count_before", 256'(fifo_count), 256'd2);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        name_ready = 1'b0;
        @(negedge clk);
        checkOutput("spp_count_after", 256'(fifo_count), 256'd2);
        checkOutput("spp_head", name_out, {32'h22, 32'h33, 192'd0});
        setReady(1'b1);
        waitDrain();

        // Asynchronous reset in the middle of a name, with a queued entry
        setReady(1'b0);
        wq = {32'h77};
        sendName();
        applyStimulus(32'h101, 1'b0);
        applyStimulus(32'h102, 1'b0);
        applyStimulus(32'h103, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 256'(name_valid), 256'd0);
        checkOutput("mid_rst_count", 256'(fifo_count), 256'd0);
        checkOutput("mid_rst_ready", 256'(in_ready), 256'd1);
        checkOutput("mid_rst_name", name_out, 256'd0);
        checkOutput("mid_rst_len", 256'(name_len), 256'd0);
        checkOutput("mid_rst_trunc", 256'(name_trunc), 256'd0);
        sbq.delete();
        @(negedge clk);
        #2;
        rst = 1'b0;
        name_ready = 1'b1;
        wq = {32'h201, 32'h202};
        sendName();
        waitDrain();

        checkOutput("sb_left", 256'(sbq.size()), 256'd0);
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
